// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: HALT/FETCH/DECODE/EXEC sequencer, carry and zero flags,
// program-load and debug ports, and a valid-qualified memory-mapped output register.
module acc_cpu_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int OUT_ADDR = 2**ADDR_W-1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              cf,
  output logic              zf,
  output logic              halted,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_STO = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_JC  = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ac_reg;
  logic [DATA_W-1:0] md_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [2:0]        ir_op_reg;
  logic [ADDR_W-1:0] ir_addr_reg;
  logic              cf_reg;
  logic              zf_reg;
  logic              out_valid_reg;

  // Control strobes decoded from the current state
  logic              start_en;
  logic              fetch_en;
  logic              decode_en;
  logic              exec_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              out_fire;
  logic              jump_taken;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_HALT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_HALT:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (ir_op_reg == OP_HLT) ? S_HALT : S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  always_comb begin
    halted    = (state_reg == S_HALT);
    start_en  = halted && start;
    fetch_en  = (state_reg == S_FETCH);
    decode_en = (state_reg == S_DECODE);
    exec_en   = (state_reg == S_EXEC);
    out_fire  = exec_en && (ir_op_reg == OP_STO) && (ir_addr_reg == OUT_A);
    // Reset in the same cycle aborts any pending store or program write
    mem_we    = !reset && ((halted && prog_we) || (exec_en && ir_op_reg == OP_STO));
    mem_waddr = halted ? prog_addr : ir_addr_reg;
    mem_wdata = halted ? prog_data : ac_reg;
  end

  always_comb begin
    jump_taken = 1'b0;
    unique case (ir_op_reg)
      OP_JZ:   jump_taken = zf_reg;
      OP_JC:   jump_taken = cf_reg;
      OP_JMP:  jump_taken = 1'b1;
      default: jump_taken = 1'b0;
    endcase
  end

  // Top bit of diff is the borrow because both operands are zero-extended
  assign sum  = {1'b0, ac_reg} + {1'b0, md_reg};
  assign diff = {1'b0, ac_reg} - {1'b0, md_reg};

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg        <= '0;
      ac_reg        <= '0;
      md_reg        <= '0;
      ir_op_reg     <= '0;
      ir_addr_reg   <= '0;
      cf_reg        <= 1'b0;
      zf_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_fire;
      if (out_fire) out_data_reg <= ac_reg;
      if (start_en) pc_reg <= start_pc;
      if (fetch_en) begin
        ir_op_reg   <= mem[pc_reg][DATA_W-1 -: 3];
        ir_addr_reg <= mem[pc_reg][ADDR_W-1:0];
      end
      if (decode_en) begin
        pc_reg <= pc_reg + ADDR_W'(1);
        md_reg <= mem[ir_addr_reg];
      end
      if (exec_en) begin
        if (jump_taken) pc_reg <= ir_addr_reg;
        unique case (ir_op_reg)
          OP_LDA: begin
            ac_reg <= md_reg;
            zf_reg <= (md_reg == '0);
          end
          OP_ADD: begin
            ac_reg <= sum[DATA_W-1:0];
            cf_reg <= sum[DATA_W];
            zf_reg <= (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            ac_reg <= diff[DATA_W-1:0];
            cf_reg <= diff[DATA_W];
            zf_reg <= (diff[DATA_W-1:0] == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_data  = mem[dbg_addr];
  assign pc        = pc_reg;
  assign ac        = ac_reg;
  assign cf        = cf_reg;
  assign zf        = zf_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param: directed programs plus random forward-jump
// programs, all compared against an instruction-level interpreter of the ISA.
module tb_acc_cpu_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] start_pc = '0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [4:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       cf, zf, halted, out_valid;
  logic [7:0] out_data;

  acc_cpu_param #(.DATA_W(8), .ADDR_W(5), .OUT_ADDR(31)) dut (
    .clock(clock), .reset(reset), .start(start), .start_pc(start_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .ac(ac), .cf(cf), .zf(zf),
    .halted(halted), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Program image and reference-model state (persists across runs like the CPU)
  logic [7:0] img [32];
  logic [7:0] m   [32];
  logic [7:0] m_ac, m_out;
  logic       m_cf, m_zf;
  logic [4:0] m_pc;
  int         m_steps;
  int         exp_stamp[$];
  logic [7:0] exp_val[$];
  int         got_stamp[$];
  logic [7:0] got_val[$];
  int         n_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  // Instruction-level interpreter: one loop iteration per instruction, 3 cycles each
  task automatic model_run(input logic [4:0] sp);
    logic [4:0] p;
    logic [2:0] op;
    logic [4:0] a;
    logic [8:0] s;
    bit         done;
    for (int i = 0; i < 32; i++) m[i] = img[i];
    p = sp;
    m_steps = 0;
    done = 0;
    exp_stamp.delete();
    exp_val.delete();
    while (!done && m_steps < 100) begin
      op = m[p][7:5];
      a  = m[p][4:0];
      p  = p + 5'd1;
      m_steps++;
      case (op)
        3'd0: done = 1;
        3'd1: begin m_ac = m[a]; m_zf = (m_ac == 8'd0); end
        3'd2: begin
          s = {1'b0, m_ac} + {1'b0, m[a]};
          m_cf = s[8];
          m_ac = s[7:0];
          m_zf = (m_ac == 8'd0);
        end
        3'd3: begin
          m[a] = m_ac;
          if (a == 5'd31) begin
            exp_stamp.push_back(3 * m_steps);
            exp_val.push_back(m_ac);
            m_out = m_ac;
          end
        end
        3'd4: begin
          m_cf = (m_ac < m[a]);
          m_ac = m_ac - m[a];
          m_zf = (m_ac == 8'd0);
        end
        3'd5: if (m_zf) p = a;
        3'd6: if (m_cf) p = a;
        default: p = a;
      endcase
    end
    m_pc = p;
  endtask

  // Loads the image; the word at sp is written in the same cycle as start
  task automatic load_and_start(input logic [4:0] sp);
    for (int i = 0; i < 32; i++) begin
      if (5'(i) != sp) begin
        prog_we = 1'b1; prog_addr = 5'(i); prog_data = img[i];
        tick();
      end
    end
    prog_we = 1'b1; prog_addr = sp; prog_data = img[sp];
    start = 1'b1; start_pc = sp;
    tick();
    prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic run_prog(input string name, input logic [4:0] sp, input bit noise);
    model_run(sp);
    load_and_start(sp);
    got_stamp.delete();
    got_val.delete();
    n_cyc = 0;
    while (halted !== 1'b1 && n_cyc < 300) begin
      if (noise) begin
        prog_we = 1'b1;
        prog_addr = 5'($urandom_range(0, 31));
        prog_data = 8'($urandom_range(0, 255));
      end
      tick();
      n_cyc++;
      prog_we = 1'b0;
      if (out_valid === 1'b1) begin
        got_stamp.push_back(n_cyc);
        got_val.push_back(out_data);
      end
    end
    check({name, "_cycles"}, n_cyc, 3 * m_steps);
    check({name, "_ac"}, ac, m_ac);
    check({name, "_cf"}, cf, m_cf);
    check({name, "_zf"}, zf, m_zf);
    check({name, "_pc"}, pc, m_pc);
    check({name, "_outv_idle"}, out_valid, 0);
    check({name, "_out_data"}, out_data, m_out);
    check({name, "_npulse"}, got_stamp.size(), exp_stamp.size());
    for (int k = 0; k < got_stamp.size() && k < exp_stamp.size(); k++) begin
      check({name, "_pulse_cyc"}, got_stamp[k], exp_stamp[k]);
      check({name, "_pulse_val"}, got_val[k], exp_val[k]);
    end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      check($sformatf("%s_mem%0d", name, a), dbg_data, m[a]);
    end
    $display("run %s sp=%0d instr=%0d cycles=%0d ac=%02h cf=%0b zf=%0b pc=%0d pulses=%0d",
             name, sp, m_steps, n_cyc, ac, cf, zf, pc, got_stamp.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with start held high
    reset = 1'b1; start = 1'b1; start_pc = 5'd7;
    tick();
    check("rst_halted", halted, 1);
    check("rst_pc", pc, 0);
    check("rst_ac", ac, 0);
    check("rst_cf", cf, 0);
    check("rst_zf", zf, 0);
    check("rst_outv", out_valid, 0);
    check("rst_outd", out_data, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_still_halted", halted, 1);
    m_ac = 8'h00; m_cf = 1'b0; m_zf = 1'b0; m_out = 8'h00;

    // Arithmetic program at 8
    clear_img();
    img[3] = 8'd3; img[4] = 8'd2; img[5] = 8'd1;
    img[8] = 8'h23; img[9] = 8'h84; img[10] = 8'h45; img[11] = 8'h67; img[12] = 8'h00;
    run_prog("arith", 5'd8, 1'b0);
    dbg_addr = 5'd7; #1;
    check("arith_m7_const", dbg_data, 8'd2);
    check("arith_ac_const", ac, 8'd2);
    check("arith_pc_const", pc, 5'd13);
    check("arith_cyc_const", n_cyc, 15);

    // Carry then JC taken to 20
    clear_img();
    img[1] = 8'hFF; img[2] = 8'h01;
    img[8] = 8'h21; img[9] = 8'h42; img[10] = 8'hD4; img[11] = 8'h00; img[20] = 8'h00;
    run_prog("carry", 5'd8, 1'b0);
    check("carry_ac_const", ac, 8'h00);
    check("carry_cf_const", cf, 1);
    check("carry_zf_const", zf, 1);
    check("carry_pc_const", pc, 5'd21);

    // Borrow then JZ not taken
    clear_img();
    img[3] = 8'd3; img[4] = 8'd2;
    img[8] = 8'h24; img[9] = 8'h83; img[10] = 8'hB4; img[11] = 8'h00; img[20] = 8'h00;
    run_prog("borrow", 5'd8, 1'b0);
    check("borrow_ac_const", ac, 8'hFF);
    check("borrow_cf_const", cf, 1);
    check("borrow_zf_const", zf, 0);
    check("borrow_pc_const", pc, 5'd12);

    // Output port: STO 31 pulses, STO 7 does not
    clear_img();
    img[1] = 8'h5A;
    img[8] = 8'h21; img[9] = 8'h7F; img[10] = 8'h67; img[11] = 8'h00;
    run_prog("outp", 5'd8, 1'b0);
    check("outp_npulse_const", got_stamp.size(), 1);
    check("outp_data_const", out_data, 8'h5A);
    dbg_addr = 5'd31; #1;
    check("outp_m31_const", dbg_data, 8'h5A);

    // PC wraps from 31 to 0
    clear_img();
    img[1] = 8'h33; img[31] = 8'h21; img[0] = 8'h00;
    run_prog("wrap", 5'd31, 1'b1);
    check("wrap_pc_const", pc, 5'd1);
    check("wrap_ac_const", ac, 8'h33);

    // Random forward-jump programs with write noise while running
    for (int t = 0; t < 20; t++) begin
      logic [2:0] op;
      logic [4:0] a;
      clear_img();
      for (int i = 0; i < 16; i++) begin
        if (i == 15 || $urandom_range(0, 9) == 0) begin
          img[i] = 8'h00;
        end else begin
          op = 3'($urandom_range(1, 7));
          if (op >= 3'd5) a = 5'($urandom_range(i + 1, 15));
          else            a = 5'($urandom_range(16, 31));
          img[i] = {op, a};
        end
      end
      for (int i = 16; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      run_prog($sformatf("rand%0d", t), 5'($urandom_range(0, 7)), 1'b1);
    end

    // Reset during EXEC of STO 31 aborts the store and the pulse
    clear_img();
    img[1] = 8'h77; img[31] = 8'h11;
    img[8] = 8'h21; img[9] = 8'h7F; img[10] = 8'h00;
    load_and_start(5'd8);
    got_stamp.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid === 1'b1) got_stamp.push_back(i);
    end
    check("abort_running", halted, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (out_valid === 1'b1) got_stamp.push_back(99);
    check("abort_halted", halted, 1);
    check("abort_pc", pc, 0);
    check("abort_ac", ac, 0);
    check("abort_outd", out_data, 0);
    tick();
    if (out_valid === 1'b1) got_stamp.push_back(100);
    check("abort_npulse", got_stamp.size(), 0);
    dbg_addr = 5'd31; #1;
    check("abort_m31", dbg_data, 8'h11);
    $display("run abort sp=8 m31=%02h halted=%0b", dbg_data, halted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised, synthesizable successor of the team's 3-bit-opcode accumulator CPU.
- Data width, address width and the memory-mapped output location are generics.
- Adds a proper carry/borrow flag, correctly sensed conditional jumps, a program-load port usable while halted, a debug read port and a valid-qualified output port.
- Sits as a teaching core under a testbench or board wrapper that loads the program and starts it.

Parameters:
DATA_W, 8, word width of AC, MD and memory; must be >= ADDR_W+3
ADDR_W, 5, address width; memory depth is 2**ADDR_W words
OUT_ADDR, 2**ADDR_W-1, an STO to this address also drives the output port

Ports:
clock  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  in HALT: begin execution at start_pc
start_pc  in  ADDR_W  first instruction address
prog_we  in  1  memory write strobe; honoured only in HALT
prog_addr  in  ADDR_W  program write address
prog_data  in  DATA_W  program write data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  MEM[dbg_addr], combinational
pc  out  ADDR_W  program counter
ac  out  DATA_W  accumulator
cf  out  1  carry/borrow flag
zf  out  1  zero flag
halted  out  1  high in HALT state
out_valid  out  1  one-cycle pulse on STO to OUT_ADDR
out_data  out  DATA_W  value stored; held until next pulse

Behaviour:
- Instruction word: opcode = bits [DATA_W-1:DATA_W-3], address = bits [ADDR_W-1:0]. Unused middle bits are ignored.
- Opcodes:
  - 000 HLT
  - 001 LDA: AC<=M[a]
  - 010 ADD: AC<=AC+M[a]
  - 011 STO: M[a]<=AC
  - 100 SUB: AC<=AC-M[a]
  - 101 JZ: if ZF then PC<=a
  - 110 JC: if CF then PC<=a
  - 111 JMP: PC<=a
- Memory: register array with asynchronous read and synchronous write. Reset does not clear it.
- States: HALT, FETCH, DECODE, EXEC.
  - HALT: when start=1, PC<=start_pc and go to FETCH.
  - FETCH: IR<=M[PC]; go to DECODE.
  - DECODE: PC<=PC+1, wrapping from 2**ADDR_W-1 to 0; MD<=M[IR addr]; go to EXEC.
  - EXEC: perform the op. HLT goes to HALT; all other ops go to FETCH.
- Latency: every instruction takes 3 cycles. A program of N instructions ending in HLT has halted=1 on the cycle 3N after the start edge.
- Arithmetic:
  - ADD computes a DATA_W+1-bit sum; CF = carry out; AC = sum mod 2**DATA_W.
  - SUB: CF = borrow (AC < M[a]); AC = difference mod 2**DATA_W.
  - ZF = (new AC == 0).
- Flags:
  - LDA updates ZF only.
  - ADD and SUB update CF and ZF.
  - STO, jumps and HLT leave both flags unchanged.
- Jump targets: a taken jump overrides the PC+1 written in DECODE. A not-taken jump leaves PC+1.
- STO to OUT_ADDR:
  - writes memory;
  - out_data<=AC;
  - out_valid=1 for exactly the EXEC-following cycle.
  - out_valid is 0 at all other times.
- prog_we:
  - in HALT: M[prog_addr]<=prog_data.
  - outside HALT: ignored, no write.
- start and prog_we in the same HALT cycle: both take effect. The first FETCH sees the written word.
- start outside HALT is ignored.
- Reset values: state=HALT, halted=1, PC=0, AC=0, CF=0, ZF=0, IR=0, MD=0, out_valid=0, out_data=0.
- Reset mid-instruction: the instruction is aborted with no memory write and no out_valid; reset values apply next cycle.

Test Plan:
- Reset: assert reset 1 cycle with start=1 -> halted=1, pc=0, ac=0, cf=zf=0, out_valid=0; start is ignored during reset.
- Arithmetic program (DATA_W=8, ADDR_W=5): load M3=3, M4=2, M5=1 and at 8 the sequence LDA 3, SUB 4, ADD 5, STO 7, HLT; start_pc=8 -> halted 15 cycles after start; dbg M7=2; ac=2, cf=0, zf=0; pc=13.
- Carry and JC: M1=FF, M2=01; program LDA 1, ADD 2, JC 20, HLT, with HLT at 20 -> ac=00, cf=1, zf=1; halt reached via address 20 (pc=21).
- Borrow and JZ not taken: LDA M4(=2), SUB M3(=3), JZ 20, HLT -> ac=FF, cf=1, zf=0; JZ not taken; pc after halt = following address + 1.
- Output port: ac=5A, STO 31 -> out_valid high exactly 1 cycle, out_data=5A, dbg M31=5A; STO 7 gives no pulse.
- Wrap and protection:
  - LDA at address 31 -> next fetch from address 0.
  - prog_we during run -> memory unchanged.
  - reset asserted in EXEC of STO -> no write, halted next cycle.
